// File: rtl/ipgu_window_addr_gen_if.sv
// Port bundle for the IPGU window address generator: frame control in, address beats out.
// Handshake: a beat transfers on a rising edge where out_valid && out_ready; while out_valid is
// high and out_ready is low the producer holds every beat field stable and does not retract it.
interface ipgu_window_addr_gen_if #(
  parameter int ADDR_W  = 9,
  parameter int SCL_W   = 8,
  parameter int MAX_WIN = 15,
  parameter int FRAC_W  = 4
);
  localparam int NW_W = $clog2(MAX_WIN + 1);

  logic              start;
  logic              abort;
  logic [NW_W-1:0]   num_win_x;
  logic [NW_W-1:0]   num_win_y;
  logic [FRAC_W+3:0] scale_num;
  logic              out_ready;
  logic              out_valid;
  logic [ADDR_W-1:0] addr_x;
  logic [ADDR_W-1:0] addr_y;
  logic [SCL_W-1:0]  scaled_x;
  logic [SCL_W-1:0]  scaled_y;
  logic              win_first;
  logic              win_last;
  logic              busy;
  logic              frame_done;
  logic              cfg_err;
  logic              state_dbg;

  modport master (
    output start, abort, num_win_x, num_win_y, scale_num, out_ready,
    input  out_valid, addr_x, addr_y, scaled_x, scaled_y, win_first, win_last,
           busy, frame_done, cfg_err, state_dbg
  );

  modport slave (
    input  start, abort, num_win_x, num_win_y, scale_num, out_ready,
    output out_valid, addr_x, addr_y, scaled_x, scaled_y, win_first, win_last,
           busy, frame_done, cfg_err, state_dbg
  );
endinterface

// File: rtl/ipgu_window_addr_gen.sv
// Window address generator: walks a frame as a grid of overlapping WIN x WIN windows and
// emits raw and fixed-point-scaled pixel addresses, one per valid/ready beat.
module ipgu_window_addr_gen #(
  parameter int ADDR_W  = 9,
  parameter int SCL_W   = 8,
  parameter int WIN     = 20,
  parameter int STRIDE  = 10,
  parameter int MAX_WIN = 15,
  parameter int FRAC_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  ipgu_window_addr_gen_if.slave  bus
);
  localparam int NW_W   = $clog2(MAX_WIN + 1);
  localparam int OFF_W  = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int SC_W   = FRAC_W + 4;
  localparam int PROD_W = ADDR_W + SC_W;

  if (WIN < 2) begin : g_bad_win
    $error("ipgu_window_addr_gen: WIN must be at least 2");
  end
  if (STRIDE < 1 || STRIDE > WIN) begin : g_bad_stride
    $error("ipgu_window_addr_gen: STRIDE must be in 1..WIN");
  end
  if ((MAX_WIN - 1) * STRIDE + WIN - 1 >= (1 << ADDR_W)) begin : g_bad_addr_w
    $error("ipgu_window_addr_gen: ADDR_W too narrow for the window grid");
  end

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state;
  logic [NW_W-1:0]   nwx, nwy;
  logic [SC_W-1:0]   scale;
  logic [NW_W-1:0]   wx, wy;
  logic [OFF_W-1:0]  off_x, off_y;
  logic [ADDR_W-1:0] org_x, org_y;
  logic              gen_done;   // final beat of the frame already sits in the output register
  logic              out_final;  // output register holds the final beat of the frame

  function automatic logic [SCL_W-1:0] scale_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [SC_W-1:0]   s);
    logic [PROD_W-1:0] p;
    p = (PROD_W'(a) * PROD_W'(s)) >> FRAC_W;
    if (p > PROD_W'((1 << SCL_W) - 1)) begin
      return '1;
    end else begin
      return p[SCL_W-1:0];
    end
  endfunction

  logic [ADDR_W-1:0] nxt_x, nxt_y;
  logic [SCL_W-1:0]  nxt_sx, nxt_sy;
  logic              off_x_end, off_y_end, wx_end, wy_end;
  logic              load_en, hs, cfg_ok;

  assign nxt_x     = org_x + ADDR_W'(off_x);
  assign nxt_y     = org_y + ADDR_W'(off_y);
  assign nxt_sx    = scale_addr(nxt_x, scale);
  assign nxt_sy    = scale_addr(nxt_y, scale);
  assign off_x_end = (off_x == OFF_W'(WIN - 1));
  assign off_y_end = (off_y == OFF_W'(WIN - 1));
  assign wx_end    = (wx == nwx - NW_W'(1));
  assign wy_end    = (wy == nwy - NW_W'(1));
  assign hs        = bus.out_valid && bus.out_ready;
  assign load_en   = (state == S_RUN) && !gen_done && (!bus.out_valid || bus.out_ready);
  assign cfg_ok    = (bus.num_win_x != '0) && (bus.num_win_x <= NW_W'(MAX_WIN)) &&
                     (bus.num_win_y != '0) && (bus.num_win_y <= NW_W'(MAX_WIN));

  assign bus.busy      = (state == S_RUN);
  assign bus.state_dbg = (state == S_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      nwx            <= '0;
      nwy            <= '0;
      scale          <= '0;
      wx             <= '0;
      wy             <= '0;
      off_x          <= '0;
      off_y          <= '0;
      org_x          <= '0;
      org_y          <= '0;
      gen_done       <= 1'b0;
      out_final      <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.addr_x     <= '0;
      bus.addr_y     <= '0;
      bus.scaled_x   <= '0;
      bus.scaled_y   <= '0;
      bus.win_first  <= 1'b0;
      bus.win_last   <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.cfg_err    <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      bus.cfg_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          // abort outranks start while idle
          if (bus.start && !bus.abort) begin
            if (cfg_ok) begin
              state    <= S_RUN;
              nwx      <= bus.num_win_x;
              nwy      <= bus.num_win_y;
              scale    <= bus.scale_num;
              wx       <= '0;
              wy       <= '0;
              off_x    <= '0;
              off_y    <= '0;
              org_x    <= '0;
              org_y    <= '0;
              gen_done <= 1'b0;
            end else begin
              bus.cfg_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            state         <= S_IDLE;
            bus.out_valid <= 1'b0;
            wx            <= '0;
            wy            <= '0;
            off_x         <= '0;
            off_y         <= '0;
            org_x         <= '0;
            org_y         <= '0;
            gen_done      <= 1'b0;
            out_final     <= 1'b0;
          end else if (load_en) begin
            bus.out_valid <= 1'b1;
            bus.addr_x    <= nxt_x;
            bus.addr_y    <= nxt_y;
            bus.scaled_x  <= nxt_sx;
            bus.scaled_y  <= nxt_sy;
            bus.win_first <= (off_x == '0) && (off_y == '0);
            bus.win_last  <= off_x_end && off_y_end;
            out_final     <= off_x_end && off_y_end && wx_end && wy_end;
            // Advance: pixel raster inside the window, then window raster across the frame
            if (!off_x_end) begin
              off_x <= off_x + OFF_W'(1);
            end else begin
              off_x <= '0;
              if (!off_y_end) begin
                off_y <= off_y + OFF_W'(1);
              end else begin
                off_y <= '0;
                if (!wx_end) begin
                  wx    <= wx + NW_W'(1);
                  org_x <= org_x + ADDR_W'(STRIDE);
                end else begin
                  wx    <= '0;
                  org_x <= '0;
                  if (!wy_end) begin
                    wy    <= wy + NW_W'(1);
                    org_y <= org_y + ADDR_W'(STRIDE);
                  end else begin
                    gen_done <= 1'b1;
                  end
                end
              end
            end
          end else if (hs && out_final) begin
            state          <= S_IDLE;
            bus.out_valid  <= 1'b0;
            bus.frame_done <= 1'b1;
            out_final      <= 1'b0;
            gen_done       <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ipgu_window_addr_gen.sv
// Bench for ipgu_window_addr_gen: scoreboarded beat streams on a WIN=4/STRIDE=2 instance plus a
// narrow-scaled-output instance for saturation.
module tb_ipgu_window_addr_gen;
  localparam int ADDR_W  = 9;
  localparam int WIN     = 4;
  localparam int STRIDE  = 2;
  localparam int MAX_WIN = 15;
  localparam int FRAC_W  = 4;

  typedef struct packed {
    logic [8:0] ax;
    logic [8:0] ay;
    logic [7:0] sx;
    logic [7:0] sy;
    logic       first;
    logic       last;
    logic       fin;
  } beat_t;
  localparam int BEAT_W = $bits(beat_t);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ipgu_window_addr_gen_if #(.ADDR_W(ADDR_W), .SCL_W(8), .MAX_WIN(MAX_WIN), .FRAC_W(FRAC_W)) bus ();
  ipgu_window_addr_gen_if #(.ADDR_W(ADDR_W), .SCL_W(4), .MAX_WIN(MAX_WIN), .FRAC_W(FRAC_W)) bus_s ();

  ipgu_window_addr_gen #(.ADDR_W(ADDR_W), .SCL_W(8), .WIN(WIN), .STRIDE(STRIDE),
                         .MAX_WIN(MAX_WIN), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  ipgu_window_addr_gen #(.ADDR_W(ADDR_W), .SCL_W(4), .WIN(WIN), .STRIDE(STRIDE),
                         .MAX_WIN(MAX_WIN), .FRAC_W(FRAC_W)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s)
  );

  int vectors     = 0;
  int miscompares = 0;
  logic [BEAT_W-1:0] exp_q[$];
  logic [BEAT_W-1:0] exp_s_q[$];
  logic [BEAT_W-1:0] e_m, e_s;
  int   beat_cnt   = 0;
  int   beat_s_cnt = 0;
  logic done_due   = 1'b0;
  logic have_held  = 1'b0;
  logic [BEAT_W-2:0] held;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t make_beat(input int ax, input int ay, input int scale,
                                      input int sat_max, input bit first, input bit last,
                                      input bit fin);
    beat_t b;
    int sx, sy;
    sx = (ax * scale) >> FRAC_W;
    sy = (ay * scale) >> FRAC_W;
    if (sx > sat_max) sx = sat_max;
    if (sy > sat_max) sy = sat_max;
    b.ax = 9'(ax);
    b.ay = 9'(ay);
    b.sx = 8'(sx);
    b.sy = 8'(sy);
    b.first = first;
    b.last  = last;
    b.fin   = fin;
    return b;
  endfunction

  task automatic gen_frame(input int nwx, input int nwy, input int scale, input bit to_s);
    beat_t b;
    for (int wy = 0; wy < nwy; wy++)
      for (int wx = 0; wx < nwx; wx++)
        for (int fy = 0; fy < WIN; fy++)
          for (int fx = 0; fx < WIN; fx++) begin
            b = make_beat(wx * STRIDE + fx, wy * STRIDE + fy, scale, to_s ? 15 : 255,
                          (fx == 0) && (fy == 0), (fx == WIN - 1) && (fy == WIN - 1),
                          (wx == nwx - 1) && (wy == nwy - 1) && (fx == WIN - 1) && (fy == WIN - 1));
            if (to_s) exp_s_q.push_back(b);
            else      exp_q.push_back(b);
          end
  endtask

  function automatic logic [BEAT_W-2:0] cur_main();
    return {bus.addr_x, bus.addr_y, bus.scaled_x, bus.scaled_y, bus.win_first, bus.win_last};
  endfunction

  function automatic logic [BEAT_W-2:0] cur_s();
    return {bus_s.addr_x, bus_s.addr_y, 4'b0, bus_s.scaled_x, 4'b0, bus_s.scaled_y,
            bus_s.win_first, bus_s.win_last};
  endfunction

  // Main scoreboard: beats accepted on the coming edge, stall stability, frame_done timing
  always @(negedge clk) begin
    if (!rst) begin
      if (done_due || bus.frame_done) check_val("frame_done", 64'(bus.frame_done), 64'(done_due));
      done_due = 1'b0;
      if (have_held && bus.out_valid) check_val("stall_hold", 64'(cur_main()), 64'(held));
      have_held = 1'b0;
      if (bus.out_valid && bus.out_ready && !bus.abort) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_beat", 64'(cur_main()), 64'(0) - 64'(1));
        end else begin
          e_m = exp_q.pop_front();
          check_val("beat", 64'(cur_main()), 64'(e_m[BEAT_W-1:1]));
          if (e_m[0]) done_due = 1'b1;
        end
        beat_cnt++;
      end else if (bus.out_valid) begin
        have_held = 1'b1;
        held      = cur_main();
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus_s.out_valid && bus_s.out_ready) begin
      if (exp_s_q.size() == 0) begin
        check_val("unexpected_beat_s", 64'(cur_s()), 64'(0) - 64'(1));
      end else begin
        e_s = exp_s_q.pop_front();
        check_val("beat_s", 64'(cur_s()), 64'(e_s[BEAT_W-1:1]));
      end
      if (beat_s_cnt == 146) begin
        check_val("sat_addr_x", 64'(bus_s.addr_x), 64'd20);
        check_val("sat_scaled_x", 64'(bus_s.scaled_x), 64'd15);
      end
      beat_s_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int nwx, input int nwy, input int scale);
    bus.num_win_x = 4'(nwx);
    bus.num_win_y = 4'(nwy);
    bus.scale_num = 8'(scale);
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.num_win_x = 4'd0;
    bus.num_win_y = 4'd0;
    bus.scale_num = 8'd0;
  endtask

  task automatic wait_frame(input bit rnd);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || bus.busy) && g < 3000) begin
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      g++;
    end
    if (g >= 3000) check_val("frame_timeout", 64'(exp_q.size()), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic wait_beats(input int base, input int n);
    int g;
    g = 0;
    while (beat_cnt - base < n && g < 500) begin
      tick();
      g++;
    end
    if (g >= 500) check_val("beat_wait_timeout", 64'(beat_cnt - base), 64'(n));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, g, nwx, nwy, sc;
    bus.start = 1'b0;   bus.abort = 1'b0;   bus.out_ready = 1'b1;
    bus.num_win_x = '0; bus.num_win_y = '0; bus.scale_num = '0;
    bus_s.start = 1'b0; bus_s.abort = 1'b0; bus_s.out_ready = 1'b1;
    bus_s.num_win_x = '0; bus_s.num_win_y = '0; bus_s.scale_num = '0;

    // Reset state
    repeat (3) tick();
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_addr", 64'({bus.addr_x, bus.addr_y}), 64'd0);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_state", 64'(bus.state_dbg), 64'd0);
    check_val("rst_pulses", 64'({bus.frame_done, bus.cfg_err}), 64'd0);
    rst = 1'b0;
    tick();

    // Basic 2x2 frame, unity scale, with start-to-first-beat latency
    gen_frame(2, 2, 16, 1'b0);
    bus.num_win_x = 4'd2; bus.num_win_y = 4'd2; bus.scale_num = 8'd16;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.num_win_x = 4'd0;
    check_val("lat_edge1_valid", 64'(bus.out_valid), 64'd0);
    check_val("lat_edge1_busy", 64'(bus.busy), 64'd1);
    tick();
    check_val("lat_edge2_valid", 64'(bus.out_valid), 64'd1);
    wait_frame(1'b0);
    check_val("t1_idle", 64'(bus.busy), 64'd0);

    // Same frame under random back-pressure
    gen_frame(2, 2, 16, 1'b0);
    start_frame(2, 2, 16);
    wait_frame(1'b1);

    // Half scale, then a few random configurations
    gen_frame(3, 2, 8, 1'b0);
    start_frame(3, 2, 8);
    wait_frame(1'b0);
    for (int i = 0; i < 3; i++) begin
      nwx = $urandom_range(1, 3);
      nwy = $urandom_range(1, 3);
      sc  = $urandom_range(0, 255);
      gen_frame(nwx, nwy, sc, 1'b0);
      start_frame(nwx, nwy, sc);
      wait_frame(1'b1);
    end

    // Saturation on the 4-bit scaled instance
    gen_frame(10, 1, 32, 1'b1);
    bus_s.num_win_x = 4'd10; bus_s.num_win_y = 4'd1; bus_s.scale_num = 8'd32;
    bus_s.start = 1'b1;
    tick();
    bus_s.start = 1'b0;
    g = 0;
    while ((exp_s_q.size() != 0 || bus_s.busy) && g < 400) begin
      tick();
      g++;
    end
    check_val("sat_beat_count", 64'(beat_s_cnt), 64'd160);

    // Rejected configuration
    bus.num_win_x = 4'd0; bus.num_win_y = 4'd2; bus.scale_num = 8'd16;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_val("cfg_err_pulse", 64'(bus.cfg_err), 64'd1);
    check_val("cfg_err_busy", 64'(bus.busy), 64'd0);
    tick();
    check_val("cfg_err_clear", 64'(bus.cfg_err), 64'd0);
    repeat (3) tick();
    check_val("cfg_err_no_beat", 64'(bus.out_valid), 64'd0);

    // start while running is ignored
    gen_frame(2, 2, 16, 1'b0);
    start_frame(2, 2, 16);
    repeat (5) tick();
    bus.num_win_x = 4'd3; bus.num_win_y = 4'd3; bus.scale_num = 8'd8;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_frame(1'b0);
    check_val("restart_ignored_idle", 64'(bus.busy), 64'd0);

    // abort on beat 10
    gen_frame(2, 2, 16, 1'b0);
    base = beat_cnt;
    start_frame(2, 2, 16);
    wait_beats(base, 10);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_val("abort_valid", 64'(bus.out_valid), 64'd0);
    check_val("abort_busy", 64'(bus.busy), 64'd0);
    check_val("abort_beats", 64'(beat_cnt - base), 64'd10);
    exp_q.delete();
    repeat (4) tick();
    check_val("abort_no_done", 64'(bus.frame_done), 64'd0);
    gen_frame(2, 2, 16, 1'b0);
    start_frame(2, 2, 16);
    wait_frame(1'b0);

    // Asynchronous reset at beat 20
    gen_frame(2, 2, 16, 1'b0);
    base = beat_cnt;
    start_frame(2, 2, 16);
    wait_beats(base, 20);
    rst = 1'b1;
    #1;
    check_val("arst_valid", 64'(bus.out_valid), 64'd0);
    check_val("arst_addr", 64'({bus.addr_x, bus.addr_y}), 64'd0);
    check_val("arst_scaled", 64'({bus.scaled_x, bus.scaled_y}), 64'd0);
    check_val("arst_flags", 64'({bus.win_first, bus.win_last, bus.busy}), 64'd0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    gen_frame(2, 2, 16, 1'b0);
    bus.num_win_x = 4'd2; bus.num_win_y = 4'd2; bus.scale_num = 8'd16;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_val("post_rst_edge1_valid", 64'(bus.out_valid), 64'd0);
    tick();
    check_val("post_rst_edge2_valid", 64'(bus.out_valid), 64'd1);
    check_val("post_rst_first_addr", 64'({bus.addr_x, bus.addr_y}), 64'd0);
    wait_frame(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
